// File: rtl/hslp_div_16by8_if.sv
// hslp_div_16by8_if: valid/ready operand and result bus for the restoring divider
interface hslp_div_16by8_if #(parameter int W = 8);
  logic in_valid, in_ready, out_valid, out_ready, ovf, dz;
  logic [2*W-1:0] prod;
  logic [W-1:0] b, quo, rem;
  modport master(output in_valid, prod, b, out_ready, input in_ready, out_valid, quo, rem, ovf, dz);
  modport slave(input in_valid, prod, b, out_ready, output in_ready, out_valid, quo, rem, ovf, dz);
endinterface

// File: rtl/hslp_div_16by8.sv
// hslp_div_16by8: sequential restoring divider, 2W-bit dividend by W-bit divisor, one quotient bit per clock
module hslp_div_16by8 #(parameter int W = 8) (
  input logic clk,
  input logic rst,
  hslp_div_16by8_if.slave bus
);
  localparam int CW = $clog2(W + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q;
  logic [W-1:0] r_q, r_d, q_q, q_d, b_q, quo_q, rem_q;
  logic [W:0] r_sh;
  logic [CW-1:0] cnt_q;
  logic in_ready_q, out_valid_q, ovf_q, dz_q, ge;
  // partial remainder stays below b, so W bits suffice outside the shifted compare
  always_comb begin
    r_sh = {r_q, q_q[W-1]};
    ge = r_sh >= {1'b0, b_q};
    r_d = ge ? W'(r_sh - {1'b0, b_q}) : r_sh[W-1:0];
    q_d = {q_q[W-2:0], ge};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      in_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      quo_q <= '0;
      rem_q <= '0;
      ovf_q <= 1'b0;
      dz_q <= 1'b0;
      cnt_q <= '0;
      r_q <= '0;
      q_q <= '0;
      b_q <= '0;
    end else
      case (state_q)
        IDLE: if (bus.in_valid) begin
          b_q <= bus.b;
          r_q <= bus.prod[2*W-1:W];
          q_q <= bus.prod[W-1:0];
          cnt_q <= CW'(W);
          in_ready_q <= 1'b0;
          if (bus.b == '0 || bus.prod[2*W-1:W] >= bus.b) begin
            state_q <= DONE;
            out_valid_q <= 1'b1;
            quo_q <= '1;
            rem_q <= '0;
            dz_q <= bus.b == '0;
            ovf_q <= bus.b != '0;
          end else
            state_q <= RUN;
        end
        RUN: begin
          r_q <= r_d;
          q_q <= q_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            state_q <= DONE;
            out_valid_q <= 1'b1;
            quo_q <= q_d;
            rem_q <= r_d;
            ovf_q <= 1'b0;
            dz_q <= 1'b0;
          end
        end
        DONE: if (bus.out_ready) begin
          state_q <= IDLE;
          out_valid_q <= 1'b0;
          in_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.quo = quo_q;
  assign bus.rem = rem_q;
  assign bus.ovf = ovf_q;
  assign bus.dz = dz_q;
endmodule

// File: tb/tb_hslp_div_16by8.sv
// tb_hslp_div_16by8: directed and randomized checks of the divider against an arithmetic model
module tb_hslp_div_16by8;
  logic clk = 1'b0, rst = 1'b1;
  int errors = 0, checks = 0;
  hslp_div_16by8_if #(.W(8)) bus();
  hslp_div_16by8 #(.W(8)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run_op(input logic [15:0] p, input logic [7:0] d, input int stall, input bit pulse);
    int edges, eq, er, lat;
    bit edz, eovf;
    edz = d == 0;
    eovf = !edz && (p / d) > 255;
    eq = (edz || eovf) ? 255 : p / d;
    er = (edz || eovf) ? 0 : p % d;
    lat = (edz || eovf) ? 1 : 9;
    @(negedge clk);
    chk("in_ready_idle", bus.in_ready, 1);
    bus.in_valid = 1'b1; bus.prod = p; bus.b = d;
    @(negedge clk);
    bus.in_valid = 1'b0; bus.prod = $urandom; bus.b = $urandom;
    edges = 1;
    while (!bus.out_valid && edges < 40) begin @(negedge clk); edges++; end
    chk("latency", edges, lat);
    chk("out_valid", bus.out_valid, 1);
    chk("quo", bus.quo, eq);
    chk("rem", bus.rem, er);
    chk("dz", bus.dz, edz);
    chk("ovf", bus.ovf, eovf);
    if (!edz && !eovf) begin
      chk("invariant", bus.quo * d + bus.rem, p);
      chk("rem_lt_b", bus.rem < d, 1);
    end
    for (int i = 0; i < stall; i++) begin
      if (pulse) begin bus.in_valid = i[0]; bus.prod = 16'h0100; bus.b = 8'h01; end
      @(negedge clk);
      chk("hold_valid", bus.out_valid, 1);
      chk("hold_quo", bus.quo, eq);
      chk("hold_rem", bus.rem, er);
      chk("hold_in_ready", bus.in_ready, 0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("post_valid", bus.out_valid, 0);
    chk("post_in_ready", bus.in_ready, 1);
    chk("post_quo", bus.quo, eq);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.prod = '0; bus.b = '0;
    #12;
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_quo", bus.quo, 0);
    chk("rst_rem", bus.rem, 0);
    chk("rst_ovf", bus.ovf, 0);
    chk("rst_dz", bus.dz, 0);
    @(negedge clk); rst = 1'b0;
    run_op(16'h3FC1, 8'hFF, 0, 0);
    chk("t1_quo", bus.quo, 8'h40);
    run_op(16'h1234, 8'h00, 0, 0);
    chk("t2_dz", bus.dz, 1);
    run_op(16'h0800, 8'h08, 0, 0);
    chk("t3_ovf", bus.ovf, 1);
    run_op(16'h0063, 8'h0A, 5, 1);
    chk("t4_rem", bus.rem, 8'h09);
    @(negedge clk);
    chk("t4_no_ghost", bus.out_valid, 0);
    bus.in_valid = 1'b1; bus.prod = 16'h7FFF; bus.b = 8'h80;
    @(negedge clk); bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1; #1;
    chk("t5_rst_valid", bus.out_valid, 0);
    chk("t5_rst_ready", bus.in_ready, 1);
    @(negedge clk); rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("t5_no_spurious", bus.out_valid, 0);
    chk("t5_idle", bus.in_ready, 1);
    run_op(16'h7FFF, 8'h80, 0, 0);
    chk("t5_quo", bus.quo, 8'hFF);
    chk("t5_rem", bus.rem, 8'h7F);
    for (int n = 0; n < 3000; n++) begin
      logic [15:0] p;
      logic [7:0] d;
      p = 16'($urandom);
      d = 8'($urandom);
      if (n % 4 == 0) p[15:8] = 8'($urandom_range(0, int'(d)));
      run_op(p, d, $urandom_range(0, 3), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
